cu_ls_seq: RTL and testbench

Multi-cycle load/store control unit for the LEGv8 datapath. It decodes STUR/LDUR/STURB/LDURB/STURH/LDURH and sequences the access as one or more bus beats against a memory that signals completion with `mem_ready`. It adds a write-back cycle for loads and a timeout fault. It sits beside the other CU_* decoders and drives the same 37-bit control word into the datapath during the execute phase.

---
 rtl/cu_ls_seq.sv | 194 +++++++++++++++++++
 tb/tb_cu_ls_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cu_ls_seq.sv
// LEGv8 load/store control unit: multi-beat memory sequencing with
// load write-back cycle and per-beat wait timeout.
module cu_ls_seq #(
  parameter int CUL       = 36,
  parameter int MEM_BYTES = 8,
  parameter int WAIT_MAX  = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [31:0]  IR,
  input  logic [3:0]   status,
  input  logic         mem_ready,
  output logic [3:0]   NS,
  output logic [2:0]   k_mux,
  output logic [CUL:0] controlWord,
  output logic [2:0]   beat,
  output logic         busy,
  output logic         done,
  output logic         fault
);

  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STURH = 11'b01111000000;
  localparam logic [10:0] OP_LDURH = 11'b01111000010;
  localparam logic [10:0] OP_STURB = 11'b00111000000;
  localparam logic [10:0] OP_LDURB = 11'b00111000010;

  function automatic logic [1:0] sz_enc(input int b);
    case (b)
      8:       return 2'b11;
      4:       return 2'b10;
      2:       return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  localparam int N8 = (MEM_BYTES < 8) ? 8 / MEM_BYTES : 1;
  localparam int N2 = (MEM_BYTES < 2) ? 2 : 1;
  localparam logic [2:0] L8 = 3'(N8 - 1);
  localparam logic [2:0] L2 = 3'(N2 - 1);
  localparam logic [1:0] SZ8 = sz_enc((MEM_BYTES < 8) ? MEM_BYTES : 8);
  localparam logic [1:0] SZ2 = sz_enc((MEM_BYTES < 2) ? MEM_BYTES : 2);
  localparam logic [7:0] WLAST = 8'(WAIT_MAX - 1);

  typedef struct packed {
    logic       ok;
    logic       ld;
    logic [2:0] last;
    logic [1:0] sz;
  } dec_t;

  function automatic dec_t decode(input logic [10:0] op);
    dec_t d;
    d = '0;
    unique case (1'b1)
      op == OP_STUR:  d = {1'b1, 1'b0, L8, SZ8};
      op == OP_LDUR:  d = {1'b1, 1'b1, L8, SZ8};
      op == OP_STURH: d = {1'b1, 1'b0, L2, SZ2};
      op == OP_LDURH: d = {1'b1, 1'b1, L2, SZ2};
      op == OP_STURB: d = {1'b1, 1'b0, 3'd0, 2'b00};
      op == OP_LDURB: d = {1'b1, 1'b1, 3'd0, 2'b00};
      default:        d = '0;
    endcase
    return d;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE, S_ACCESS, S_WB, S_DONE, S_FAULT
  } state_t;

  state_t      state, state_nx;
  logic [31:0] ir_q, ir_nx;
  logic [2:0]  beat_q, beat_nx;
  logic [7:0]  wait_q, wait_nx;
  dec_t        dec_in, dec_q;

  assign dec_in = decode(IR[31:21]);
  assign dec_q  = decode(ir_q[31:21]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ir_q   <= '0;
      beat_q <= '0;
      wait_q <= '0;
    end else begin
      state  <= state_nx;
      ir_q   <= ir_nx;
      beat_q <= beat_nx;
      wait_q <= wait_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ir_nx    = ir_q;
    beat_nx  = beat_q;
    wait_nx  = wait_q;
    unique case (state)
      S_IDLE: begin
        beat_nx = '0;
        wait_nx = '0;
        if (start && dec_in.ok) begin
          ir_nx    = IR;
          state_nx = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem_ready) begin
          wait_nx = '0;
          if (beat_q != dec_q.last) begin
            beat_nx = beat_q + 3'd1;
          end else begin
            state_nx = dec_q.ld ? S_WB : S_DONE;
          end
        end else begin
          wait_nx = wait_q + 8'd1;
          if (wait_q == WLAST) state_nx = S_FAULT;
        end
      end
      S_WB: state_nx = S_DONE;
      S_DONE, S_FAULT: begin
        state_nx = S_IDLE;
        beat_nx  = '0;
        wait_nx  = '0;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  logic [4:0] fs, sa, sb, da;
  logic       w_reg, b_sel, mwe;
  logic [1:0] mem_cs, size, dts, pc_fs;
  logic [35:0] cw;

  always_comb begin
    fs     = '0;
    sa     = '0;
    sb     = '0;
    da     = '0;
    w_reg  = 1'b0;
    b_sel  = 1'b0;
    mwe    = 1'b0;
    mem_cs = 2'b00;
    size   = 2'b00;
    dts    = 2'b00;
    pc_fs  = 2'b00;
    NS     = 4'b0000;
    k_mux  = 3'b000;
    busy   = 1'b0;
    if (state != S_IDLE) begin
      busy  = 1'b1;
      k_mux = 3'b001;
      NS    = 4'b0100;
      fs    = 5'b01000;
      sa    = ir_q[9:5];
      sb    = ir_q[4:0];
      da    = ir_q[4:0];
      b_sel = 1'b1;
      size  = dec_q.sz;
    end
    unique case (state)
      S_ACCESS: begin
        mem_cs = 2'b01;
        mwe    = ~dec_q.ld;
        dts    = dec_q.ld ? 2'b11 : 2'b01;
      end
      S_WB: begin
        mem_cs = 2'b01;
        w_reg  = 1'b1;
        dts    = 2'b11;
      end
      S_DONE: begin
        NS    = 4'b0000;
        pc_fs = 2'b01;
      end
      S_FAULT: NS = 4'b0000;
      default: ;
    endcase
  end

  assign cw = {fs, sa, sb, da, w_reg, 1'b0, mem_cs, b_sel, mwe,
               1'b0, 1'b0, size, 1'b0, dts, 1'b0, pc_fs};
  assign controlWord = {{(CUL - 35){1'b0}}, cw};
  assign beat  = beat_q;
  assign done  = (state == S_DONE);
  assign fault = (state == S_FAULT);

  logic unused_ok;
  assign unused_ok = ^{status, ir_q[20:10]};

endmodule

// File: tb/tb_cu_ls_seq.sv
// Directed bench for cu_ls_seq: a cycle table on an 8-byte bus instance
// plus hand sequences for multi-beat, timeout and async reset cases.
module tb_cu_ls_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ir = '0;
  logic [3:0]  status = 4'b1010;
  logic        rdy = 1'b0;

  logic [3:0]  ns8, ns2;
  logic [2:0]  km8, km2, bt8, bt2;
  logic [36:0] cw8, cw2;
  logic        bz8, bz2, dn8, dn2, ft8, ft2;

  always #5 clk = ~clk;

  cu_ls_seq #(.CUL(36), .MEM_BYTES(8), .WAIT_MAX(4)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .IR(ir),
    .status(status), .mem_ready(rdy), .NS(ns8), .k_mux(km8),
    .controlWord(cw8), .beat(bt8), .busy(bz8), .done(dn8),
    .fault(ft8)
  );

  cu_ls_seq #(.CUL(36), .MEM_BYTES(2), .WAIT_MAX(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .IR(ir),
    .status(status), .mem_ready(rdy), .NS(ns2), .k_mux(km2),
    .controlWord(cw2), .beat(bt2), .busy(bz2), .done(dn2),
    .fault(ft2)
  );

  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STURH = 11'b01111000000;
  localparam logic [10:0] OP_STURB = 11'b00111000000;
  localparam logic [10:0] OP_BAD   = 11'b10001011000;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] mkir(input logic [10:0] op,
                                       input logic [4:0] a,
                                       input logic [4:0] b);
    return {op, 11'd0, a, b};
  endfunction

  // Field packing of the control word; act=0 gives the IDLE word.
  function automatic logic [36:0] mkcw(
    input logic act, input logic w, input logic [1:0] mcs,
    input logic mwe, input logic [1:0] sz, input logic [1:0] dts,
    input logic [1:0] pcfs, input logic [31:0] i);
    if (!act) return '0;
    return {1'b0, 5'b01000, i[9:5], i[4:0], i[4:0], w, 1'b0, mcs,
            1'b1, mwe, 1'b0, 1'b0, sz, 1'b0, dts, 1'b0, pcfs};
  endfunction

  typedef struct {
    logic        st;
    logic [31:0] ir;
    logic        rdy;
    logic        busy;
    logic        done;
    logic        fault;
    logic [3:0]  ns;
    logic [2:0]  beat;
    logic [36:0] cw;
  } vec_t;

  function automatic vec_t v(
    input logic st, input logic [31:0] i, input logic r,
    input logic b, input logic d, input logic f,
    input logic [3:0] n, input logic [2:0] bt, input logic [36:0] c);
    vec_t x;
    x.st = st; x.ir = i; x.rdy = r; x.busy = b; x.done = d;
    x.fault = f; x.ns = n; x.beat = bt; x.cw = c;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    rdy   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  vec_t tbl[$];

  initial begin
    logic [31:0] ir_ld, ir_sb, ir_bad, ir_sh, ir_st, ir_l2;
    logic [36:0] c;
    ir_ld  = mkir(OP_LDUR, 5'd2, 5'd9);
    ir_sb  = mkir(OP_STURB, 5'd3, 5'd7);
    ir_bad = mkir(OP_BAD, 5'd1, 5'd1);
    ir_sh  = mkir(OP_STURH, 5'd1, 5'd4);
    ir_st  = mkir(OP_STUR, 5'd5, 5'd6);
    ir_l2  = mkir(OP_LDUR, 5'd4, 5'd8);

    // LDUR single beat: ACCESS, WB, DONE, IDLE
    c = mkcw(1, 0, 2'b01, 0, 2'b11, 2'b11, 2'b00, ir_ld);
    tbl.push_back(v(1, ir_ld, 1, 1, 0, 0, 4'b0100, 0, c));
    c = mkcw(1, 1, 2'b01, 0, 2'b11, 2'b11, 2'b00, ir_ld);
    tbl.push_back(v(0, ir_ld, 1, 1, 0, 0, 4'b0100, 0, c));
    c = mkcw(1, 0, 2'b00, 0, 2'b11, 2'b00, 2'b01, ir_ld);
    tbl.push_back(v(0, ir_ld, 1, 1, 1, 0, 4'b0000, 0, c));
    tbl.push_back(v(0, ir_ld, 1, 0, 0, 0, 4'b0000, 0, '0));
    // STURB: no WB
    c = mkcw(1, 0, 2'b01, 1, 2'b00, 2'b01, 2'b00, ir_sb);
    tbl.push_back(v(1, ir_sb, 1, 1, 0, 0, 4'b0100, 0, c));
    c = mkcw(1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, ir_sb);
    tbl.push_back(v(0, ir_sb, 1, 1, 1, 0, 4'b0000, 0, c));
    tbl.push_back(v(0, ir_sb, 0, 0, 0, 0, 4'b0000, 0, '0));
    // invalid opcode ignored
    tbl.push_back(v(1, ir_bad, 1, 0, 0, 0, 4'b0000, 0, '0));
    // STURH with one wait cycle; start while busy ignored
    c = mkcw(1, 0, 2'b01, 1, 2'b01, 2'b01, 2'b00, ir_sh);
    tbl.push_back(v(1, ir_sh, 0, 1, 0, 0, 4'b0100, 0, c));
    tbl.push_back(v(1, ir_ld, 0, 1, 0, 0, 4'b0100, 0, c));
    c = mkcw(1, 0, 2'b00, 0, 2'b01, 2'b00, 2'b01, ir_sh);
    tbl.push_back(v(0, ir_ld, 1, 1, 1, 0, 4'b0000, 0, c));
    tbl.push_back(v(0, ir_ld, 1, 0, 0, 0, 4'b0000, 0, '0));
    // STUR: ready arrives on the cycle the timeout would fire
    c = mkcw(1, 0, 2'b01, 1, 2'b11, 2'b01, 2'b00, ir_st);
    tbl.push_back(v(1, ir_st, 0, 1, 0, 0, 4'b0100, 0, c));
    tbl.push_back(v(0, ir_st, 0, 1, 0, 0, 4'b0100, 0, c));
    tbl.push_back(v(0, ir_st, 0, 1, 0, 0, 4'b0100, 0, c));
    tbl.push_back(v(0, ir_st, 0, 1, 0, 0, 4'b0100, 0, c));
    c = mkcw(1, 0, 2'b00, 0, 2'b11, 2'b00, 2'b01, ir_st);
    tbl.push_back(v(0, ir_st, 1, 1, 1, 0, 4'b0000, 0, c));
    tbl.push_back(v(0, ir_st, 0, 0, 0, 0, 4'b0000, 0, '0));

    do_reset();
    chk("rst_cw8", cw8, '0);
    chk("rst_cw2", cw2, '0);
    chk("rst_ns8", ns8, 0);
    chk("rst_flags8", {bz8, dn8, ft8, km8, bt8}, '0);
    chk("rst_flags2", {bz2, dn2, ft2, km2, bt2}, '0);

    foreach (tbl[k]) begin
      start = tbl[k].st;
      ir    = tbl[k].ir;
      rdy   = tbl[k].rdy;
      tick();
      chk($sformatf("v%0d_busy", k), bz8, tbl[k].busy);
      chk($sformatf("v%0d_done", k), dn8, tbl[k].done);
      chk($sformatf("v%0d_fault", k), ft8, tbl[k].fault);
      chk($sformatf("v%0d_ns", k), ns8, tbl[k].ns);
      chk($sformatf("v%0d_kmux", k), km8, {2'b00, tbl[k].busy});
      chk($sformatf("v%0d_beat", k), bt8, tbl[k].beat);
      chk($sformatf("v%0d_cw", k), cw8, tbl[k].cw);
    end

    // 4-beat LDUR on the 2-byte bus
    do_reset();
    start = 1'b1; ir = ir_l2; rdy = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mb_beat%0d", i), bt2, 3'(i));
      chk($sformatf("mb_cw%0d", i), cw2,
          mkcw(1, 0, 2'b01, 0, 2'b01, 2'b11, 2'b00, ir_l2));
      tick();
    end
    chk("mb_wb_cw", cw2, mkcw(1, 1, 2'b01, 0, 2'b01, 2'b11, 2'b00, ir_l2));
    tick();
    chk("mb_done", {dn2, ns2}, {1'b1, 4'b0000});
    chk("mb_done_cw", cw2, mkcw(1, 0, 2'b00, 0, 2'b01, 2'b00, 2'b01, ir_l2));
    tick();
    chk("mb_idle", {bz2, bt2, cw2}, '0);

    // timeout: STUR with ready held low
    do_reset();
    start = 1'b1; ir = ir_st; rdy = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_wait%0d", i), {bz8, ft8, bz2, ft2}, 4'b1010);
      tick();
    end
    chk("to_fault8", {ft8, dn8, ns8}, {2'b10, 4'b0000});
    chk("to_cw8", cw8, mkcw(1, 0, 2'b00, 0, 2'b11, 2'b00, 2'b00, ir_st));
    chk("to_fault2", {ft2, ns2}, {1'b1, 4'b0000});
    chk("to_cw2", cw2, mkcw(1, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00, ir_st));
    tick();
    chk("to_idle", {bz8, ft8, bz2, ft2}, 4'b0000);

    // async reset mid-ACCESS of a 4-beat load, then a STURH
    do_reset();
    start = 1'b1; ir = ir_l2; rdy = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("ar_beat1", bt2, 3'd1);
    rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cw", cw2, '0);
    chk("ar_out", {ns2, km2, bt2, bz2, dn2, ft2}, '0);
    tick();
    rst_n = 1'b1;
    start = 1'b1; ir = ir_sh; rdy = 1'b1;
    tick();
    start = 1'b0;
    chk("ar_sh_cw", cw2, mkcw(1, 0, 2'b01, 1, 2'b01, 2'b01, 2'b00, ir_sh));
    tick();
    chk("ar_sh_done", {dn2, bz2}, 2'b11);
    tick();
    chk("ar_sh_idle", {bz2, cw2}, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
